gobou_bias_issuer: RTL and testbench

- Initiator side of the gobou bias-stage control protocol.
- On a start request, emits one `in_begin` pulse, a contiguous burst of `in_valid` beats with matching bias-memory read addresses, and an `in_end` pulse on the last beat.
- Then waits out the bias-stage pipeline and acknowledges completion.
- Sits between the gobou layer sequencer and the bias control/bias memory stage.

---
 rtl/gobou_bias_pkg.sv | 18 +
 rtl/gobou_bias_cnt.sv | 29 ++
 rtl/gobou_bias_issuer.sv | 124 ++++++++++++
 tb/tb_gobou_bias_issuer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/gobou_bias_pkg.sv
// Shared definitions for the gobou bias-stage initiator: state encoding
// and the default widths and latency values.
package gobou_bias_pkg;

    localparam int OUTW_DEF       = 12;
    localparam int BWADDR_DEF     = 12;
    // Cycles from the last issued beat until the bias stage emits its delayed out_end.
    localparam int BIAS_STAGE_LAT = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEGIN = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/gobou_bias_cnt.sv
// Loadable down-counter with zero and one flags. Decrement saturates at zero.
module gobou_bias_cnt #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         xrst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] value_reg;

    always_ff @(posedge clk) begin
        if (xrst) begin
            value_reg <= '0;
        end else if (load) begin
            value_reg <= load_val;
        end else if (dec && !zero) begin
            value_reg <= value_reg - W'(1);
        end
    end

    assign zero = (value_reg == '0);
    assign last = (value_reg == W'(1));

endmodule

// File: rtl/gobou_bias_issuer.sv
// Initiator of the gobou bias-stage protocol: begin pulse, a burst of
// addressed beats with end on the last one, a drain wait, then ack.
module gobou_bias_issuer
    import gobou_bias_pkg::*;
#(
    parameter int OUTW      = OUTW_DEF,
    parameter int BWADDR    = BWADDR_DEF,
    parameter int DRAIN_CYC = BIAS_STAGE_LAT
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [OUTW-1:0]   total_out,
    input  logic [BWADDR-1:0] bias_base,
    output logic              busy,
    output logic              ack,
    output logic              out_begin,
    output logic              out_valid,
    output logic              out_end,
    output logic [BWADDR-1:0] bias_addr
);

    // A zero drain would break the begin/ack ordering downstream; clamp to one.
    localparam int DRAIN_EFF = (DRAIN_CYC < 1) ? 1 : DRAIN_CYC;
    localparam int DW        = $clog2(DRAIN_EFF + 1);

    state_t state_reg;

    logic accept;
    logic beat_load, beat_dec, beat_zero, beat_last;
    logic drain_load, drain_dec, drain_zero, drain_last;

    assign accept     = (state_reg == S_IDLE) && req && (total_out != '0);
    assign beat_load  = accept;
    assign beat_dec   = (state_reg == S_BEGIN) || ((state_reg == S_RUN) && !beat_zero);
    assign drain_load = (state_reg == S_RUN) && beat_zero;
    assign drain_dec  = (state_reg == S_DRAIN) && !drain_zero;

    // Remaining beats still to be issued.
    gobou_bias_cnt #(.W(OUTW)) u_beat_cnt (
        .clk      (clk),
        .xrst     (xrst),
        .load     (beat_load),
        .load_val (total_out),
        .dec      (beat_dec),
        .zero     (beat_zero),
        .last     (beat_last)
    );

    gobou_bias_cnt #(.W(DW)) u_drain_cnt (
        .clk      (clk),
        .xrst     (xrst),
        .load     (drain_load),
        .load_val (DW'(DRAIN_EFF)),
        .dec      (drain_dec),
        .zero     (drain_zero),
        .last     (drain_last)
    );

    always_ff @(posedge clk) begin
        if (xrst) begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
            ack       <= 1'b0;
            out_begin <= 1'b0;
            out_valid <= 1'b0;
            out_end   <= 1'b0;
            bias_addr <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        if (total_out != '0) begin
                            state_reg <= S_BEGIN;
                            out_begin <= 1'b1;
                            bias_addr <= bias_base;
                        end else begin
                            state_reg <= S_DONE;
                            ack       <= 1'b1;
                        end
                    end
                end
                S_BEGIN: begin
                    // bias_addr already holds the latched base for the first beat.
                    state_reg <= S_RUN;
                    out_begin <= 1'b0;
                    out_valid <= 1'b1;
                    out_end   <= beat_last;
                end
                S_RUN: begin
                    if (beat_zero) begin
                        state_reg <= S_DRAIN;
                        out_valid <= 1'b0;
                        out_end   <= 1'b0;
                    end else begin
                        bias_addr <= bias_addr + BWADDR'(1);
                        out_end   <= beat_last;
                    end
                end
                S_DRAIN: begin
                    if (drain_last) begin
                        state_reg <= S_DONE;
                        ack       <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    ack       <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    ack       <= 1'b0;
                    out_begin <= 1'b0;
                    out_valid <= 1'b0;
                    out_end   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gobou_bias_issuer.sv
// Randomized bench for gobou_bias_issuer; expected traces come from the
// cycle-offset timing rules of a transaction.
module tb_gobou_bias_issuer;

    localparam int OUTW   = 12;
    localparam int BWADDR = 12;
    localparam int D      = 2;

    logic              clk = 1'b0;
    logic              xrst;
    logic              req;
    logic [OUTW-1:0]   total_out;
    logic [BWADDR-1:0] bias_base;
    logic              busy, ack, out_begin, out_valid, out_end;
    logic [BWADDR-1:0] bias_addr;

    int n_checks = 0;
    int n_pass   = 0;

    gobou_bias_issuer #(.OUTW(OUTW), .BWADDR(BWADDR), .DRAIN_CYC(D)) dut (
        .clk       (clk),
        .xrst      (xrst),
        .req       (req),
        .total_out (total_out),
        .bias_base (bias_base),
        .busy      (busy),
        .ack       (ack),
        .out_begin (out_begin),
        .out_valid (out_valid),
        .out_end   (out_end),
        .bias_addr (bias_addr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observed outputs packed as {busy,ack,begin,valid,end,addr}; addr only when valid.
    function automatic logic [31:0] observed();
        return {15'd0, busy, ack, out_begin, out_valid, out_end,
                out_valid ? bias_addr : {BWADDR{1'b0}}};
    endfunction

    // Expected outputs k cycles after the accepting edge for a burst of n beats.
    function automatic logic [31:0] expected(input int n, input int base, input int k);
        int ack_cyc;
        logic b, a, bg, v, e;
        logic [BWADDR-1:0] addr;
        ack_cyc = (n == 0) ? 1 : n + 2 + D;
        b    = (k >= 1) && (k <= ack_cyc);
        a    = (k == ack_cyc);
        bg   = (n > 0) && (k == 1);
        v    = (n > 0) && (k >= 2) && (k <= n + 1);
        e    = v && (k == n + 1);
        addr = v ? BWADDR'((base + k - 2) % (1 << BWADDR)) : '0;
        return {15'd0, b, a, bg, v, e, addr};
    endfunction

    // Issue one request and check every cycle through the return to idle.
    // noise re-asserts req and scrambles operands while busy.
    task automatic run_txn(input int n, input int base, input bit noise);
        int ack_cyc;
        ack_cyc   = (n == 0) ? 1 : n + 2 + D;
        req       = 1'b1;
        total_out = OUTW'(n);
        bias_base = BWADDR'(base);
        step();
        for (int k = 1; k <= ack_cyc + 1; k++) begin
            check_eq($sformatf("cyc n=%0d k=%0d", n, k), observed(), expected(n, base, k));
            req       = noise && (k <= ack_cyc) && ($urandom_range(0, 1) == 1);
            total_out = noise ? OUTW'($urandom) : total_out;
            bias_base = noise ? BWADDR'($urandom) : bias_base;
            if (k <= ack_cyc) step();
        end
        req = 1'b0;
        $display("txn n=%0d base=%03h noise=%0d ack_cycle=%0d", n, base, noise, ack_cyc);
    endtask

    initial begin
        xrst      = 1'b1;
        req       = 1'b0;
        total_out = '0;
        bias_base = '0;
        step();
        step();
        xrst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("reset_idle", observed(), 32'd0);
        end

        run_txn(4, 12'h010, 1'b0);
        run_txn(1, 12'hFFF, 1'b0);
        run_txn(3, 12'hFFE, 1'b0);
        run_txn(0, 12'h123, 1'b0);
        run_txn(2, 12'h200, 1'b0);   // accepted in the cycle right after return to idle
        run_txn(5, 12'h0A0, 1'b1);

        // Reset during RUN: outputs drop next cycle and no ack ever follows.
        req       = 1'b1;
        total_out = 12'd5;
        bias_base = 12'h300;
        step();
        req = 1'b0;
        step();
        step();
        check_eq("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        xrst = 1'b1;
        step();
        xrst = 1'b0;
        check_eq("mid_reset_outs", observed(), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("post_reset_quiet", observed(), 32'd0);
        end
        run_txn(3, 12'h040, 1'b0);

        for (int t = 0; t < 30; t++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
            run_txn(n, int'($urandom_range(0, 4095)), $urandom_range(0, 1) == 1);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                step();
                check_eq("gap_idle", observed(), 32'd0);
            end
        end

        run_txn((1 << OUTW) - 1, 12'h800, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
